// File: rtl/float_decoder_pipe.sv
// Two-stage IEEE-754 decoder: sign, unbiased exponent, explicit-hidden-bit
// significand and class flags, with valid/ready flow control.
module float_decoder_pipe #(
  parameter int FSIZE     = 64,
  parameter int EXP_SIZE  = 11,
  parameter int MANT_SIZE = 52
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FSIZE-1:0]     in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXP_SIZE:0]    out_exp,
  output logic [MANT_SIZE:0]   out_sig,
  output logic                 out_zero,
  output logic                 out_sub,
  output logic                 out_inf,
  output logic                 out_nan,
  output logic                 out_qnan
);

  localparam int EXP_BIAS = (1 << (EXP_SIZE - 1)) - 1;
  localparam int EW       = EXP_SIZE + 1;
  localparam int SW       = MANT_SIZE + 1;
  localparam int LZW      = $clog2(MANT_SIZE + 1);

  typedef struct packed {
    logic                 sign;
    logic [EXP_SIZE-1:0]  e;
    logic [MANT_SIZE-1:0] f;
    logic [LZW-1:0]       lz;
    logic                 zero;
    logic                 sub;
    logic                 inf;
    logic                 nan;
    logic                 qnan;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] e;
    logic [SW-1:0] sig;
    logic          zero;
    logic          sub;
    logic          inf;
    logic          nan;
    logic          qnan;
  } out_t;

  logic v1_d, v1_q;
  logic v2_d, v2_q;
  s1_t  s1_d, s1_q;
  out_t o_d, o_q;

  logic                 s1_adv;
  logic                 s2_adv;
  logic [EXP_SIZE-1:0]  e_in;
  logic [MANT_SIZE-1:0] f_in;
  logic [LZW-1:0]       lz_in;
  logic [LZW-1:0]       sh;

  assign s2_adv   = !v2_q || out_ready;
  assign s1_adv   = !v1_q || s2_adv;
  assign in_ready = s1_adv;

  assign e_in = in_bits[FSIZE-2 -: EXP_SIZE];
  assign f_in = in_bits[MANT_SIZE-1:0];
  assign sh   = s1_q.lz + LZW'(1);

  // Last hit wins, so the highest set bit sets the count.
  always_comb begin
    lz_in = '0;
    for (int i = 0; i < MANT_SIZE; i++) begin
      if (f_in[i]) lz_in = LZW'(MANT_SIZE - 1 - i);
    end
  end

  always_comb begin
    v1_d = s1_adv ? in_valid : v1_q;
    s1_d = s1_q;
    if (s1_adv && in_valid) begin
      s1_d.sign = in_bits[FSIZE-1];
      s1_d.e    = e_in;
      s1_d.f    = f_in;
      s1_d.lz   = lz_in;
      s1_d.zero = (~|e_in) && (~|f_in);
      s1_d.sub  = (~|e_in) && (|f_in);
      s1_d.inf  = (&e_in) && (~|f_in);
      s1_d.nan  = (&e_in) && (|f_in);
      s1_d.qnan = (&e_in) && f_in[MANT_SIZE-1];
    end
  end

  always_comb begin
    v2_d = s2_adv ? v1_q : v2_q;
    o_d  = o_q;
    if (s2_adv && v1_q) begin
      o_d.sign = s1_q.sign;
      o_d.zero = s1_q.zero;
      o_d.sub  = s1_q.sub;
      o_d.inf  = s1_q.inf;
      o_d.nan  = s1_q.nan;
      o_d.qnan = s1_q.qnan;
      unique case (1'b1)
        s1_q.zero: begin
          o_d.e   = '0;
          o_d.sig = '0;
        end
        // 1-bias-(lz+1) simplifies to -bias-lz
        s1_q.sub: begin
          o_d.e   = EW'(0 - EXP_BIAS) - EW'(s1_q.lz);
          o_d.sig = {1'b0, s1_q.f} << sh;
        end
        s1_q.inf, s1_q.nan: begin
          o_d.e   = EW'(EXP_BIAS + 1);
          o_d.sig = {1'b0, s1_q.f};
        end
        default: begin
          o_d.e   = {1'b0, s1_q.e} - EW'(EXP_BIAS);
          o_d.sig = {1'b1, s1_q.f};
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      o_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      o_q  <= o_d;
    end
  end

  assign out_valid = v2_q;
  assign out_sign  = o_q.sign;
  assign out_exp   = o_q.e;
  assign out_sig   = o_q.sig;
  assign out_zero  = o_q.zero;
  assign out_sub   = o_q.sub;
  assign out_inf   = o_q.inf;
  assign out_nan   = o_q.nan;
  assign out_qnan  = o_q.qnan;

endmodule

// File: tb/tb_float_decoder_pipe.sv
// Scoreboard bench for float_decoder_pipe: binary64 and binary32 instances
// driven with directed and random words, checked against a value-level model.
module tb_float_decoder_pipe;

  typedef struct {
    logic        s;
    int          e;
    logic [63:0] sig;
    logic [4:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv64 = 0, ir64, ov64, or64 = 1;
  logic [63:0] ib64 = '0;
  logic        os64, oz64, osb64, oi64, on64, oq64;
  logic [11:0] oe64;
  logic [52:0] osig64;

  logic        iv32 = 0, ir32, ov32, or32 = 1;
  logic [31:0] ib32 = '0;
  logic        os32, oz32, osb32, oi32, on32, oq32;
  logic [8:0]  oe32;
  logic [23:0] osig32;

  float_decoder_pipe #(.FSIZE(64), .EXP_SIZE(11), .MANT_SIZE(52)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv64), .in_ready(ir64), .in_bits(ib64),
    .out_valid(ov64), .out_ready(or64),
    .out_sign(os64), .out_exp(oe64), .out_sig(osig64),
    .out_zero(oz64), .out_sub(osb64), .out_inf(oi64),
    .out_nan(on64), .out_qnan(oq64)
  );

  float_decoder_pipe #(.FSIZE(32), .EXP_SIZE(8), .MANT_SIZE(23)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .in_bits(ib32),
    .out_valid(ov32), .out_ready(or32),
    .out_sign(os32), .out_exp(oe32), .out_sig(osig32),
    .out_zero(oz32), .out_sub(osb32), .out_inf(oi32),
    .out_nan(on32), .out_qnan(oq32)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q64[$];
  exp_t q32[$];
  bit   rand_rdy = 0;

  function automatic exp_t mk(logic s, int e, logic [63:0] sig,
                              logic [4:0] fl);
    exp_t r;
    r.s = s; r.e = e; r.sig = sig; r.fl = fl;
    return r;
  endfunction

  // Value-level reference: float = sig * 2^(exp - ms) with sig MSB at bit ms.
  function automatic exp_t model(logic [63:0] b, int es, int ms);
    exp_t        r;
    int          bias = (1 << (es - 1)) - 1;
    int          emax = (1 << es) - 1;
    logic [63:0] f = b & ((64'd1 << ms) - 64'd1);
    int          e = int'((b >> ms) & 64'(emax));
    int          p = 0;
    r.s = b[es + ms];
    r.fl = 5'b0;
    if (e == 0 && f == 0) begin
      r.e = 0; r.sig = 0; r.fl = 5'b10000;
    end else if (e == 0) begin
      for (int i = 0; i < ms; i++) if (f[i]) p = i;
      r.sig = f << (ms - p);
      r.e = p + 1 - bias - ms;
      r.fl = 5'b01000;
    end else if (e == emax) begin
      r.e = bias + 1;
      r.sig = f;
      if (f == 0) r.fl = 5'b00100;
      else r.fl = {3'b000, 1'b1, f[ms-1]};
    end else begin
      r.e = e - bias;
      r.sig = f | (64'd1 << ms);
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_word(int es, int ms);
    logic [63:0] f = {$urandom, $urandom} & ((64'd1 << ms) - 64'd1);
    logic [63:0] e;
    logic [63:0] emax = (64'd1 << es) - 64'd1;
    logic [63:0] s = 64'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: begin e = 0; f = 0; end
      1: begin
        e = 0;
        f = f >> $urandom_range(0, ms - 1);
        if (f == 0) f = 1;
      end
      2: begin e = emax; f = 0; end
      3: e = emax;
      default: e = 64'($urandom_range(1, int'(emax) - 1));
    endcase
    return (s << (es + ms)) | (e << ms) | f;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  function automatic void chk_out(string nm, exp_t a, exp_t e);
    n_cmp++;
    if (a.s !== e.s || a.e != e.e || a.sig !== e.sig || a.fl !== e.fl) begin
      n_bad++;
      $display("FAIL %s: got s=%0b e=%0d sig=%h fl=%b want s=%0b e=%0d sig=%h fl=%b",
               nm, a.s, a.e, a.sig, a.fl, e.s, e.e, e.sig, e.fl);
    end
  endfunction

  // Monitors compare the head on every valid cycle, so stalls check stability.
  always @(negedge clk) begin
    if (rst_n && ov64) begin
      if (q64.size() == 0) begin
        chk("f64_unexpected_out", 64'(ov64), 64'd0);
      end else begin
        exp_t a;
        a.s = os64; a.e = int'($signed(oe64)); a.sig = 64'(osig64);
        a.fl = {oz64, osb64, oi64, on64, oq64};
        chk_out("f64_out", a, q64[0]);
        if (or64) void'(q64.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov32) begin
      if (q32.size() == 0) begin
        chk("f32_unexpected_out", 64'(ov32), 64'd0);
      end else begin
        exp_t a;
        a.s = os32; a.e = int'($signed(oe32)); a.sig = 64'(osig32);
        a.fl = {oz32, osb32, oi32, on32, oq32};
        chk_out("f32_out", a, q32[0]);
        if (or32) void'(q32.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      or64 = ($urandom_range(0, 3) != 0);
      or32 = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input bit is32, input logic [63:0] b, input exp_t e);
    int n = 0;
    bit ok = 1;
    if (is32) begin iv32 = 1; ib32 = b[31:0]; end
    else begin iv64 = 1; ib64 = b; end
    forever begin
      @(negedge clk);
      if (is32 ? ir32 : ir64) break;
      n++;
      if (n > 100) begin
        chk(is32 ? "f32_in_ready_timeout" : "f64_in_ready_timeout", 64'd0, 64'd1);
        ok = 0;
        break;
      end
    end
    if (ok) begin
      if (is32) q32.push_back(e);
      else q64.push_back(e);
    end
    @(posedge clk);
    #1;
    if (is32) iv32 = 0;
    else iv64 = 0;
  endtask

  task automatic rand_stream(input bit is32, input int n);
    for (int k = 0; k < n; k++) begin
      logic [63:0] w = is32 ? rand_word(8, 23) : rand_word(11, 52);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(is32, w, is32 ? model(w, 8, 23) : model(w, 11, 52));
    end
  endtask

  initial begin
    int t;
    logic [63:0] bp [8];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid64", 64'(ov64), 64'd0);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    chk("rst_in_ready64", 64'(ir64), 64'd1);
    chk("rst_out_data64", {oe64, osig64[51:0]}, 64'd0);
    chk("rst_flags64", 64'({os64, oz64, osb64, oi64, on64, oq64, osig64[52]}), 64'd0);
    rst_n = 1;
    @(posedge clk);
    #1;

    send(0, 64'h405ee00000000000, mk(0, 6, 64'h1ee00000000000, 5'b0));
    @(negedge clk);
    chk("latency_not_yet", 64'(ov64), 64'd0);
    @(negedge clk);
    chk("latency_two", 64'(ov64), 64'd1);
    @(posedge clk);
    #1;

    send(0, 64'h0000000000000001, mk(0, -1074, 64'h10000000000000, 5'b01000));
    send(0, 64'h8000000000000000, mk(1, 0, 64'h0, 5'b10000));
    send(0, 64'h7FF8000000000000, mk(0, 1024, 64'h8000000000000, 5'b00011));
    send(0, 64'hFFF0000000000000, mk(1, 1024, 64'h0, 5'b00100));
    send(1, 64'h3F800000, mk(0, 0, 64'h800000, 5'b0));
    send(1, 64'h00400000, mk(0, -127, 64'h800000, 5'b01000));

    repeat (4) @(posedge clk);
    #1;
    or64 = 0;
    for (int i = 0; i < 8; i++) bp[i] = rand_word(11, 52);
    send(0, bp[0], model(bp[0], 11, 52));
    send(0, bp[1], model(bp[1], 11, 52));
    @(negedge clk);
    chk("bp_in_ready_low", 64'(ir64), 64'd0);
    chk("bp_out_valid_held", 64'(ov64), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    or64 = 1;
    for (int i = 2; i < 8; i++) send(0, bp[i], model(bp[i], 11, 52));

    repeat (6) @(posedge clk);
    #1;
    send(0, 64'h3FF0000000000000, model(64'h3FF0000000000000, 11, 52));
    send(0, 64'hC000000000000000, model(64'hC000000000000000, 11, 52));
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(ov64), 64'd0);
    chk("midrst_in_ready", 64'(ir64), 64'd1);
    q64.delete();
    q32.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("postrst_no_stale", 64'(ov64), 64'd0);
    @(posedge clk);
    #1;

    rand_rdy = 1;
    fork
      rand_stream(0, 300);
      rand_stream(1, 300);
    join
    rand_rdy = 0;
    @(posedge clk);
    #1;
    or64 = 1;
    or32 = 1;

    t = 0;
    while ((q64.size() != 0 || q32.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_q64_empty", 64'(q64.size()), 64'd0);
    chk("drain_q32_empty", 64'(q32.size()), 64'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
